// File: rtl/vector_data_packer.sv
// vector_data_packer
//   Packs the leading 8, 4 or 1 lanes of each accepted ALU vector into full
//   N-lane trace lines. A partial line is zero-padded and flushed on eof.
//   The packing mode is written over the shared configId/configData bus.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   tracing               1 = accept data, 0 = ignore valid_in and hold state
//   valid_in, eof_in      input qualifier and end-of-frame flag
//   vector_in             N x DATA_WIDTH ALU result, lane 0 = element 0
//   configId, configData  config select / payload (mode = configData[1:0])
//   vector_out            packed trace line (held between emits)
//   valid_out, eof_out    one-cycle line strobe, last-line-of-frame flag
//   line_count            lines emitted since reset, wraps

// One lane of the line being assembled: keeps the buffered value below the
// fill pointer, takes input element (lane - ptr) inside the append window,
// and is zero above it, which gives the eof padding for free.
module vdp_lane #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LANE       = 0
) (
  input  logic [$clog2(N):0]                ptr,
  input  logic [$clog2(N)+1:0]              fill_end,
  input  logic [N-1:0][DATA_WIDTH-1:0]      vector_in,
  input  logic [DATA_WIDTH-1:0]             buf_lane,
  output logic [DATA_WIDTH-1:0]             lane_out
);
  localparam int PW = $clog2(N);
  localparam logic [PW+1:0] IDX = (PW+2)'(LANE);

  logic [PW-1:0] src;

  always_comb begin
    src = PW'(LANE) - ptr[PW-1:0];
    if (IDX < {1'b0, ptr})      lane_out = buf_lane;
    else if (IDX < fill_end)    lane_out = vector_in[src];
    else                        lane_out = '0;
  end
endmodule

module vector_data_packer #(
  parameter int          N                     = 8,
  parameter int          DATA_WIDTH            = 32,
  parameter int unsigned PERSONAL_CONFIG_ID    = 0,
  parameter int unsigned INITIAL_FIRMWARE_MODE = 0,
  parameter int          COUNT_WIDTH           = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tracing,
  input  logic                             valid_in,
  input  logic                             eof_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic [COUNT_WIDTH-1:0]           line_count
);
  localparam int PW = $clog2(N);
  typedef logic [PW:0] cnt_t;
  localparam cnt_t E_FULL = cnt_t'(N);
  localparam cnt_t E_HALF = cnt_t'(N / 2);
  localparam cnt_t E_ONE  = cnt_t'(1);
  localparam logic [7:0] CFG_ID = 8'(PERSONAL_CONFIG_ID);

  logic [N-1:0][DATA_WIDTH-1:0] buf_q, buf_d, line_nl;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out_q, vector_out_d;
  logic                         valid_out_q, valid_out_d;
  logic                         eof_out_q, eof_out_d;
  logic [COUNT_WIDTH-1:0]       line_count_q, line_count_d;
  logic [1:0]                   mode_q, mode_d;
  cnt_t                         ptr_q, ptr_d;
  cnt_t                         ecnt;
  logic [PW+1:0]                fill_end;
  logic                         accept, cfg_wr, full, emit;
  logic                         cfg_unused;

  assign cfg_unused = ^configData[7:2];

  // Lanes appended per accepted vector; reserved mode 3 acts as pass-through.
  always_comb begin
    case (mode_q)
      2'd1:    ecnt = E_HALF;
      2'd2:    ecnt = E_ONE;
      default: ecnt = E_FULL;
    endcase
  end

  assign fill_end = {1'b0, ptr_q} + {1'b0, ecnt};
  assign full     = (fill_end == (PW+2)'(N));
  assign accept   = valid_in & tracing;
  assign cfg_wr   = (configId == CFG_ID);
  // A config write in the same cycle drops the data, so it also blocks emit.
  assign emit     = accept & ~cfg_wr & (full | eof_in);

  for (genvar g = 0; g < N; g++) begin : g_lane
    vdp_lane #(.N(N), .DATA_WIDTH(DATA_WIDTH), .LANE(g)) u_lane (
      .ptr      (ptr_q),
      .fill_end (fill_end),
      .vector_in(vector_in),
      .buf_lane (buf_q[g]),
      .lane_out (line_nl[g])
    );
  end

  always_comb begin
    mode_d       = mode_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    vector_out_d = vector_out_q;
    valid_out_d  = 1'b0;
    eof_out_d    = 1'b0;
    line_count_d = line_count_q;
    if (cfg_wr) begin
      mode_d = configData[1:0];
      ptr_d  = '0;
      buf_d  = '0;
    end else if (accept) begin
      if (emit) begin
        vector_out_d = line_nl;
        valid_out_d  = 1'b1;
        eof_out_d    = eof_in;
        ptr_d        = '0;
        buf_d        = '0;
        line_count_d = line_count_q + COUNT_WIDTH'(1);
      end else begin
        // Buffer lanes at and above ptr are always zero, so the assembled
        // line can be stored whole.
        buf_d = line_nl;
        ptr_d = fill_end[PW:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 2'(INITIAL_FIRMWARE_MODE);
      ptr_q        <= '0;
      buf_q        <= '0;
      vector_out_q <= '0;
      valid_out_q  <= 1'b0;
      eof_out_q    <= 1'b0;
      line_count_q <= '0;
    end else begin
      mode_q       <= mode_d;
      ptr_q        <= ptr_d;
      buf_q        <= buf_d;
      vector_out_q <= vector_out_d;
      valid_out_q  <= valid_out_d;
      eof_out_q    <= eof_out_d;
      line_count_q <= line_count_d;
    end
  end

  assign vector_out = vector_out_q;
  assign valid_out  = valid_out_q;
  assign eof_out    = eof_out_q;
  assign line_count = line_count_q;
endmodule

// File: tb/tb_vector_data_packer.sv
// Directed plus randomized bench for vector_data_packer (N=8, 32-bit lanes,
// 4-bit line counter). The reference model keeps the pending partial line
// as a queue of lane values and emits when it reaches N lanes or on eof.
module tb_vector_data_packer;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [7:0] CFG_ID = 8'd0;
  localparam logic [7:0] NO_CFG = 8'hFF;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk;
  logic          rst_n;
  logic          tracing, valid_in, eof_in;
  vec_t          vector_in, vector_out;
  logic [7:0]    configId, configData;
  logic          valid_out, eof_out;
  logic [CW-1:0] line_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] pend[$];
  int            m_mode;
  int            m_cnt;
  vec_t          exp_vec;

  vector_data_packer #(
    .N(N), .DATA_WIDTH(DW), .PERSONAL_CONFIG_ID(0),
    .INITIAL_FIRMWARE_MODE(0), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .vector_in(vector_in), .configId(configId),
    .configData(configData), .vector_out(vector_out), .valid_out(valid_out),
    .eof_out(eof_out), .line_count(line_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, check outputs after the edge.
  task automatic step(input bit v, input bit e, input bit tr,
                      input logic [7:0] cid, input logic [7:0] cdat, input vec_t vec);
    int  ecnt;
    bit  ev;
    bit  ee;
    ev = 1'b0;
    ee = 1'b0;
    valid_in = v; eof_in = e; tracing = tr;
    configId = cid; configData = cdat; vector_in = vec;
    if (cid == CFG_ID) begin
      m_mode = int'(cdat[1:0]);
      pend.delete();
    end else if (v && tr) begin
      ecnt = (m_mode == 1) ? N/2 : (m_mode == 2) ? 1 : N;
      for (int i = 0; i < ecnt; i++) pend.push_back(vec[i]);
      if (pend.size() == N || e) begin
        for (int i = 0; i < N; i++) exp_vec[i] = (i < pend.size()) ? pend[i] : '0;
        ev = 1'b1;
        ee = e;
        m_cnt = (m_cnt + 1) % (1 << CW);
        pend.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("valid_out", 256'(valid_out), 256'(ev));
    chk("eof_out", 256'(eof_out), 256'(ee));
    chk("vector_out", vector_out, exp_vec);
    chk("line_count", 256'(line_count), 256'(m_cnt));
  endtask

  task automatic send(input vec_t vec, input bit e);
    step(1'b1, e, 1'b1, NO_CFG, 8'h00, vec);
  endtask

  task automatic cfg(input logic [7:0] m);
    vec_t z;
    z = '0;
    step(1'b0, 1'b0, 1'b1, CFG_ID, m, z);
  endtask

  function automatic vec_t seq(input int base);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = DW'(base + i);
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = $urandom;
    return r;
  endfunction

  // lane 0 carries the scalar; the other lanes are junk that must not leak
  function automatic vec_t scalar(input int x);
    vec_t r;
    r = rnd_vec();
    r[0] = DW'(x);
    return r;
  endfunction

  function automatic vec_t quad(input int a, input int b, input int c, input int d);
    vec_t r;
    r = rnd_vec();
    r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
    return r;
  endfunction

  // Assert reset between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    valid_in = 1'b0;
    rst_n = 1'b0;
    pend.delete();
    m_mode = 0;
    m_cnt = 0;
    exp_vec = '0;
    #1;
    chk("rst_vector_out", vector_out, 256'(0));
    chk("rst_valid_out", 256'(valid_out), 256'(0));
    chk("rst_eof_out", 256'(eof_out), 256'(0));
    chk("rst_line_count", 256'(line_count), 256'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    tracing = 1'b0; valid_in = 1'b0; eof_in = 1'b0;
    vector_in = '0; configId = NO_CFG; configData = 8'h00;
    #2;
    do_reset();

    // mode 0 pass-through
    send(seq(0), 1'b0);
    chk("first_line_count", 256'(line_count), 256'(1));

    // mode 2: eight scalars make one line
    cfg(8'd2);
    for (int i = 0; i < N; i++) send(scalar(10 + i), 1'b0);
    chk("mode2_line", vector_out, seq(10));

    // mode 1: two halves, then an early eof
    cfg(8'hFD);  // upper bits ignored, mode 1
    send(quad(1, 2, 3, 4), 1'b0);
    send(quad(5, 6, 7, 8), 1'b0);
    chk("mode1_line", vector_out, seq(1));
    send(quad(9, 9, 9, 9), 1'b1);
    chk("mode1_eof_pad", vector_out, {32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd9, 32'd9, 32'd9});

    // tracing gap retains the partial line
    cfg(8'd2);
    for (int i = 1; i <= 3; i++) send(scalar(i), 1'b0);
    for (int i = 0; i < 5; i++) step(i[0], 1'b1, 1'b0, NO_CFG, 8'h00, scalar(99));
    step(1'b0, 1'b1, 1'b1, NO_CFG, 8'h00, scalar(98));  // eof without valid
    for (int i = 4; i <= 8; i++) send(scalar(i), 1'b0);
    chk("gap_line", vector_out, seq(1));

    // config mid-line discards the partial line
    for (int i = 1; i <= 3; i++) send(scalar(i), 1'b0);
    cfg(8'd0);
    send(seq(100), 1'b0);
    // config and accept together: data dropped
    step(1'b1, 1'b1, 1'b1, CFG_ID, 8'd2, seq(200));

    // async reset mid-line
    for (int i = 0; i < 5; i++) send(scalar(50 + i), 1'b0);
    #3;
    do_reset();
    cfg(8'd2);
    for (int i = 0; i < N; i++) send(scalar(20 + i), 1'b0);
    chk("post_reset_count", 256'(line_count), 256'(1));

    // counter wrap at 2^4
    #3;
    do_reset();
    for (int i = 0; i < 17; i++) send(rnd_vec(), 1'b0);
    chk("wrap_count", 256'(line_count), 256'(1));

    // randomized traffic, including config writes and ignored config ids
    for (int i = 0; i < 600; i++) begin
      logic [7:0] cid;
      cid = ($urandom_range(0, 19) == 0) ? CFG_ID : 8'($urandom_range(1, 255));
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 8), cid, 8'($urandom), rnd_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
